// File: rtl/can_rx_fifo_pkg.sv
// Shared types and sizing helpers for the CAN receive message FIFO.
// One message is four 32-bit words, ID first.
package can_rx_fifo_pkg;

    localparam int RX_FIFO_DEPTH = 64;
    localparam int RX_MSG_W      = 128;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] dlc;
        logic [31:0] dw1;
        logic [31:0] dw2;
    } rx_msg_t;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/can_rx_fifo_ram.sv
// Message storage: synchronous write, asynchronous read, maps onto distributed RAM.
// Contents are never cleared; validity is tracked by the pointers in the top.
module can_rx_fifo_ram
    import can_rx_fifo_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic          i_sys_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  rx_msg_t       i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output rx_msg_t       o_rd_data
);

    rx_msg_t r_mem [DEPTH];

    always_ff @(posedge i_sys_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/can_rx_fifo.sv
// Receive message FIFO between the acceptance filter and the register block.
// First-word-fall-through head, registered status flags and one-cycle event pulses.
module can_rx_fifo
    import can_rx_fifo_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    localparam int AW   = ptr_width(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                i_sys_clk,
    input  logic                i_reset,
    input  logic                i_flush,
    input  logic                i_rx_w_en,
    input  logic [RX_MSG_W-1:0] i_rx_fifo_w_data,
    input  logic                i_rx_r_en,
    input  logic [AW-1:0]       i_rx_watermark,
    output logic [RX_MSG_W-1:0] o_rx_fifo_r_data,
    output logic                o_rx_full,
    output logic                o_rx_empty,
    output logic [CW-1:0]       o_rx_fill_level,
    output logic                o_rx_wm_full,
    output logic                o_rx_ok,
    output logic                o_rx_ovfl,
    output logic                o_rx_udfl
);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ok;
    logic          r_ovfl;
    logic          r_udfl;

    logic          w_clear;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [CW-1:0] w_wm_thresh;
    rx_msg_t       w_wr_msg;
    rx_msg_t       w_rd_msg;

    assign w_clear  = i_reset | i_flush;
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);

    // Flush beats a concurrent write; the dropped write is not an overflow.
    assign w_wr_acc = i_rx_w_en & ~w_full & ~w_clear;
    assign w_rd_acc = i_rx_r_en & ~w_empty & ~w_clear;

    assign w_wr_msg = rx_msg_t'(i_rx_fifo_w_data);

    can_rx_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_sys_clk (i_sys_clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_msg),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_msg)
    );

    always_ff @(posedge i_sys_clk) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (w_clear) begin
            r_ok   <= 1'b0;
            r_ovfl <= 1'b0;
            r_udfl <= 1'b0;
        end else begin
            r_ok   <= w_wr_acc;
            r_ovfl <= i_rx_w_en & w_full;
            r_udfl <= i_rx_r_en & w_empty;
        end
    end

    // Threshold fits in CW bits: watermark max is DEPTH-1.
    assign w_wm_thresh      = CW'(i_rx_watermark) + CW'(1);

    assign o_rx_full        = w_full;
    assign o_rx_empty       = w_empty;
    assign o_rx_fill_level  = r_count;
    assign o_rx_wm_full     = (r_count >= w_wm_thresh);
    assign o_rx_ok          = r_ok;
    assign o_rx_ovfl        = r_ovfl;
    assign o_rx_udfl        = r_udfl;
    assign o_rx_fifo_r_data = w_empty ? '0 : RX_MSG_W'(w_rd_msg);

endmodule

// File: tb/tb_can_rx_fifo.sv
// Directed self-checking bench for can_rx_fifo at DEPTH=4, watermark level 2.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_can_rx_fifo;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         w_en;
    logic [127:0] w_data;
    logic         r_en;
    logic [1:0]   wm;
    logic [127:0] r_data;
    logic         full;
    logic         empty;
    logic [2:0]   level;
    logic         wm_full;
    logic         ok;
    logic         ovfl;
    logic         udfl;

    int n_checks = 0;
    int n_err    = 0;

    logic [127:0] q [$];
    logic [127:0] head;

    can_rx_fifo #(.DEPTH(DEPTH)) dut (
        .i_sys_clk        (clk),
        .i_reset          (rst),
        .i_flush          (flush),
        .i_rx_w_en        (w_en),
        .i_rx_fifo_w_data (w_data),
        .i_rx_r_en        (r_en),
        .i_rx_watermark   (wm),
        .o_rx_fifo_r_data (r_data),
        .o_rx_full        (full),
        .o_rx_empty       (empty),
        .o_rx_fill_level  (level),
        .o_rx_wm_full     (wm_full),
        .o_rx_ok          (ok),
        .o_rx_ovfl        (ovfl),
        .o_rx_udfl        (udfl)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] msg(input int k);
        return {32'h100 + 32'(k), 32'd8, 32'hA000_0000 + 32'(k), 32'h5000_0000 + 32'(k)};
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; w_en = 1'b0; r_en = 1'b0;
        w_data = '0; wm = 2'd2;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        chk("rst_empty",  128'(empty),   128'd1);
        chk("rst_full",   128'(full),    128'd0);
        chk("rst_level",  128'(level),   128'd0);
        chk("rst_wm",     128'(wm_full), 128'd0);
        chk("rst_rdata",  r_data,        128'd0);
        chk("rst_pulses", 128'({ok, ovfl, udfl}), 128'd0);

        // single write, FWFT visible next cycle
        w_data = 128'h00000123_00000008_DEADBEEF_CAFEF00D;
        w_en = 1'b1;
        cycle();
        w_en = 1'b0;
        chk("wr1_empty", 128'(empty), 128'd0);
        chk("wr1_level", 128'(level), 128'd1);
        chk("wr1_rdata", r_data, 128'h00000123_00000008_DEADBEEF_CAFEF00D);
        chk("wr1_ok",    128'(ok),    128'd1);
        cycle();
        chk("wr1_ok_off", 128'(ok), 128'd0);

        r_en = 1'b1;
        cycle();
        r_en = 1'b0;
        chk("pop1_empty", 128'(empty), 128'd1);
        chk("pop1_rdata", r_data,      128'd0);
        chk("pop1_udfl",  128'(udfl),  128'd0);

        // fill to full with watermark checkpoints
        for (int k = 0; k < 4; k++) begin
            w_data = msg(k);
            w_en = 1'b1;
            cycle();
            chk("fill_level", 128'(level), 128'(k + 1));
            chk("fill_ok",    128'(ok),    128'd1);
            if (k == 1) chk("wm_at2", 128'(wm_full), 128'd0);
            if (k == 2) chk("wm_at3", 128'(wm_full), 128'd1);
            if (k == 2) chk("full_at3", 128'(full), 128'd0);
        end
        chk("full_at4", 128'(full), 128'd1);
        w_data = msg(9);
        cycle();
        w_en = 1'b0;
        chk("ovfl_pulse", 128'(ovfl),  128'd1);
        chk("ovfl_ok",    128'(ok),    128'd0);
        chk("ovfl_level", 128'(level), 128'd4);
        cycle();
        chk("ovfl_off",   128'(ovfl),  128'd0);

        // drain in order
        for (int k = 0; k < 4; k++) begin
            chk("drain_head", r_data, msg(k));
            r_en = 1'b1;
            cycle();
            r_en = 1'b0;
            chk("drain_level", 128'(level), 128'(3 - k));
            if (k == 0) chk("wm_pop_lvl3", 128'(wm_full), 128'd1);
            if (k == 1) chk("wm_pop_lvl2", 128'(wm_full), 128'd0);
        end
        chk("drain_empty", 128'(empty), 128'd1);
        chk("drain_rdata", r_data,      128'd0);

        // pop on empty
        r_en = 1'b1;
        cycle();
        r_en = 1'b0;
        chk("udfl_pulse", 128'(udfl),  128'd1);
        chk("udfl_level", 128'(level), 128'd0);

        // write + pop while empty
        w_data = msg(20);
        w_en = 1'b1; r_en = 1'b1;
        cycle();
        w_en = 1'b0; r_en = 1'b0;
        chk("wp_empty_level", 128'(level), 128'd1);
        chk("wp_empty_udfl",  128'(udfl),  128'd1);
        chk("wp_empty_ok",    128'(ok),    128'd1);
        chk("wp_empty_rdata", r_data,      msg(20));

        // steady level 2 with simultaneous write+pop, pointers wrap
        q.push_back(msg(20));
        w_data = msg(21);
        w_en = 1'b1;
        cycle();
        w_en = 1'b0;
        q.push_back(msg(21));
        chk("steady_init", 128'(level), 128'd2);
        for (int k = 0; k < 10; k++) begin
            chk("steady_head", r_data, q[0]);
            w_data = msg(30 + k);
            w_en = 1'b1; r_en = 1'b1;
            cycle();
            head = q.pop_front();
            q.push_back(msg(30 + k));
            chk("steady_level", 128'(level), 128'd2);
            chk("steady_udfl",  128'(udfl),  128'd0);
        end
        w_en = 1'b0; r_en = 1'b0;
        chk("steady_last", r_data, q[0]);

        // flush at level 3 concurrent with a write
        w_data = msg(50);
        w_en = 1'b1;
        cycle();
        chk("pre_flush_level", 128'(level), 128'd3);
        w_data = msg(51);
        flush = 1'b1;
        cycle();
        flush = 1'b0; w_en = 1'b0;
        chk("flush_empty", 128'(empty), 128'd1);
        chk("flush_level", 128'(level), 128'd0);
        chk("flush_ovfl",  128'(ovfl),  128'd0);
        chk("flush_ok",    128'(ok),    128'd0);
        chk("flush_rdata", r_data,      128'd0);

        // pointers restart after flush
        w_data = msg(60);
        w_en = 1'b1;
        cycle();
        w_en = 1'b0;
        chk("post_flush_rdata", r_data,      msg(60));
        chk("post_flush_level", 128'(level), 128'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/can_rx_fifo.md
# can_rx_fifo

Receive message FIFO between the CAN acceptance filter and the configuration register block, in the `i_sys_clk` domain. It stores accepted 128-bit messages as ID, DLC, DW1 and DW2 words, and presents the oldest one first-word-fall-through to the register read logic. It generates full, empty, watermark and overflow/underflow status for the interrupt status register. Its `o_rx_full` output is the `i_rx_full` back-pressure input of the acceptance filter stage.

## Interface
- `DEPTH`, 64, number of 128-bit entries; power of two, ≥ 2.
- `i_sys_clk`  in  1  system clock; all logic is on its rising edge.
- `i_reset`  in  1  one clock; reset is synchronous and active-high.
- `i_flush`  in  1  synchronous FIFO clear from the configuration register (SRST/CEN drop).
- `i_rx_w_en`  in  1  write strobe from the acceptance filter.
- `i_rx_fifo_w_data`  in  128  message [127:96]=ID, [95:64]=DLC, [63:32]=DW1, [31:0]=DW2.
- `i_rx_r_en`  in  1  pop strobe from register read logic (DW2 read).
- `i_rx_watermark`  in  $clog2(DEPTH)  watermark level from the watermark register.
- `o_rx_fifo_r_data`  out  128  head entry; 0 when empty.
- `o_rx_full`  out  1  count == DEPTH.
- `o_rx_empty`  out  1  count == 0.
- `o_rx_fill_level`  out  $clog2(DEPTH)+1  current count.
- `o_rx_wm_full`  out  1  watermark reached.
- `o_rx_ok`  out  1  one-cycle pulse per accepted write (RXOK).
- `o_rx_ovfl`  out  1  one-cycle pulse per dropped write (RXOFLW).
- `o_rx_udfl`  out  1  one-cycle pulse per pop attempted while empty.

## Operation
- **Storage.** The FIFO is a DEPTH×128 array with write pointer `wr_ptr`, read pointer `rd_ptr`, both $clog2(DEPTH) bits wide, and a count of $clog2(DEPTH)+1 bits.
- **Pointer wrap.** Pointers wrap naturally modulo DEPTH.
- **Write accept.** A write is accepted when `i_rx_w_en` is high and the registered `o_rx_full` is 0.
  - An accepted write stores the data at `wr_ptr`, increments `wr_ptr` and pulses `o_rx_ok`.
- **Write drop.** When `i_rx_w_en` is high while `o_rx_full` is 1, the write is dropped and `o_rx_ovfl` pulses.
  - Storage, pointers and count are unchanged.
  - A simultaneous pop does not rescue the write.
- **Pop accept.** A pop is accepted when `i_rx_r_en` is high and `o_rx_empty` is 0; `rd_ptr` increments.
- **Pop reject.** When `i_rx_r_en` is high while empty, the pop is ignored and `o_rx_udfl` pulses.
- **Count update.**
  - Count +1 on a write alone.
  - Count −1 on a pop alone.
  - Count unchanged when both are accepted in the same cycle, which is legal at any non-full, non-empty level.
- **Empty with simultaneous write.** When empty and a write and a pop arrive in the same cycle, the write is accepted, the pop is rejected (udfl pulse), and the count becomes 1.
- **Watermark.** `o_rx_wm_full` = (count ≥ `i_rx_watermark`+1).
  - A watermark value of 0 therefore asserts at 1 entry.
- **Reset and flush.** `i_reset` or `i_flush` clears the pointers, count and pulse outputs.
  - Array contents are not cleared.
  - When both a flush and a write arrive in the same cycle, the flush wins and the write is discarded without `o_rx_ovfl`.
- **Output state.** The block has no FSM; its state is the pointers and count. Every status output is a function of the registered count or a registered pulse.

## Timing
- **Reset values.**
  - `o_rx_empty` = 1.
  - `o_rx_full` = 0, `o_rx_fill_level` = 0, `o_rx_wm_full` = 0.
  - `o_rx_fifo_r_data` = 0.
  - `o_rx_ok`, `o_rx_ovfl`, `o_rx_udfl` = 0.
- **Write latency.** A write accepted at edge N clears `o_rx_empty`, updates the level and presents the data on `o_rx_fifo_r_data` after edge N, i.e. during cycle N+1.
- **Pop latency.** After a pop at edge N, the next head (or 0) is visible in cycle N+1.
  - The read path is combinational from `rd_ptr` and the array.
- **Pulse timing.** `o_rx_ok`, `o_rx_ovfl` and `o_rx_udfl` are registered: high for exactly the cycle after the triggering edge.
- **Full flag.** `o_rx_full` is registered. The filter sees full in the cycle after the write that fills the FIFO, so its next write attempt drops with an ovfl pulse.
- **Back-to-back operation.** Writes on consecutive cycles are supported, as are pops on consecutive cycles.

## Structure
- **Package `can_rx_fifo_pkg`.**
  - `rx_msg_t` packed struct {id, dlc, dw1, dw2}, 32 bits each, totalling 128 bits.
  - Localparam for the default depth.
  - Function computing the pointer width.
- **Sub-module `can_rx_fifo_ram`.** Single-clock storage with a synchronous write port and an asynchronous read port, inferable as distributed RAM.
- **Top.** Pointers, count, flag and pulse registers live in `can_rx_fifo`.

## Test plan
- **Reset.** Reset, then idle → empty=1, level=0, r_data=0. One write of 128'h00000123_00000008_DEADBEEF_CAFEF00D → next cycle empty=0, level=1, r_data equals the written value, one ok pulse.
- **Fill to full.** DEPTH=4, 4 consecutive writes → full=1 after the 4th edge. A 5th write → ovfl pulse, level stays 4. Then 4 pops → data returns in write order, empty=1.
- **Pop on empty.** Pop while empty → udfl pulse, level 0. Simultaneous write and pop while empty → level=1, udfl pulse, ok pulse.
- **Steady level.** At level 2, simultaneous write and pop for 10 cycles → level stays 2, ordering preserved, pointers wrap (DEPTH=4).
- **Watermark.** `i_rx_watermark`=2: after 2 writes wm_full=0; after the 3rd write wm_full=1; after 1 pop wm_full=0.
- **Flush.** Flush asserted at level 3 concurrently with a write → next cycle empty=1, level=0, no ovfl pulse.
